// File: rtl/ext_mem_bus_master.sv
// Single-beat initiator for the external memory bus with a ready handshake,
// a bounded wait for ready, and one recovery cycle after every access.
module ext_mem_bus_master #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] ext_mem_addr,
    output logic [DATA_W-1:0] ext_mem_data_out,
    output logic              ext_mem_data_oe,
    input  logic [DATA_W-1:0] ext_mem_data_in,
    output logic              ext_mem_read,
    output logic              ext_mem_write,
    output logic              ext_mem_cs,
    input  logic              ext_mem_ready
);

    // state   | meaning
    // IDLE    | waiting for a core request, req_ready high
    // ACCESS  | strobes on the bus, waiting for ready or timeout
    // RECOVER | one dead cycle, absorbs a responder holding ready late
    typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

    // Timeout fires on the edge that would take the count to TIMEOUT.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            state, state_nx;
    logic [7:0]        cnt, cnt_nx;
    logic              req_ready_nx, rsp_valid_nx, rsp_error_nx;
    logic [DATA_W-1:0] rsp_rdata_nx, data_out_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic              oe_nx, rd_nx, wr_nx, cs_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            req_ready        <= 1'b1;
            rsp_valid        <= 1'b0;
            rsp_error        <= 1'b0;
            rsp_rdata        <= '0;
            ext_mem_addr     <= '0;
            ext_mem_data_out <= '0;
            ext_mem_data_oe  <= 1'b0;
            ext_mem_read     <= 1'b0;
            ext_mem_write    <= 1'b0;
            ext_mem_cs       <= 1'b0;
        end else begin
            state            <= state_nx;
            cnt              <= cnt_nx;
            req_ready        <= req_ready_nx;
            rsp_valid        <= rsp_valid_nx;
            rsp_error        <= rsp_error_nx;
            rsp_rdata        <= rsp_rdata_nx;
            ext_mem_addr     <= addr_nx;
            ext_mem_data_out <= data_out_nx;
            ext_mem_data_oe  <= oe_nx;
            ext_mem_read     <= rd_nx;
            ext_mem_write    <= wr_nx;
            ext_mem_cs       <= cs_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        req_ready_nx = req_ready;
        rsp_valid_nx = 1'b0;
        rsp_error_nx = rsp_error;
        rsp_rdata_nx = rsp_rdata;
        addr_nx      = ext_mem_addr;
        data_out_nx  = ext_mem_data_out;
        oe_nx        = ext_mem_data_oe;
        rd_nx        = ext_mem_read;
        wr_nx        = ext_mem_write;
        cs_nx        = ext_mem_cs;

        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    addr_nx      = req_addr;
                    cs_nx        = 1'b1;
                    rd_nx        = ~req_write;
                    wr_nx        = req_write;
                    cnt_nx       = '0;
                    req_ready_nx = 1'b0;
                    state_nx     = ACCESS;
                    if (req_write) begin
                        oe_nx       = 1'b1;
                        data_out_nx = req_wdata;
                    end
                end
            end
            ACCESS: begin
                if (ext_mem_ready || cnt == TO_LAST) begin
                    if (ext_mem_ready && ext_mem_read)
                        rsp_rdata_nx = ext_mem_data_in;
                    rsp_valid_nx = 1'b1;
                    rsp_error_nx = ~ext_mem_ready;
                    cs_nx        = 1'b0;
                    rd_nx        = 1'b0;
                    wr_nx        = 1'b0;
                    oe_nx        = 1'b0;
                    state_nx     = RECOVER;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            RECOVER: begin
                cnt_nx       = '0;
                req_ready_nx = 1'b1;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ext_mem_bus_master.sv
// Directed bench for ext_mem_bus_master: a behavioural responder with selectable
// ready behaviour, and a scoreboard that checks every response pulse.
module tb_ext_mem_bus_master;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid, rsp_error;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] ext_mem_addr;
    logic [DATA_W-1:0] ext_mem_data_out, ext_mem_data_in;
    logic              ext_mem_data_oe, ext_mem_read, ext_mem_write, ext_mem_cs;
    logic              ext_mem_ready;

    ext_mem_bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .ext_mem_addr(ext_mem_addr), .ext_mem_data_out(ext_mem_data_out),
        .ext_mem_data_oe(ext_mem_data_oe), .ext_mem_data_in(ext_mem_data_in),
        .ext_mem_read(ext_mem_read), .ext_mem_write(ext_mem_write),
        .ext_mem_cs(ext_mem_cs), .ext_mem_ready(ext_mem_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int cyc   = 0;
    int acc_cyc;

    // expected response: {error, rdata}
    logic [8:0] exp_q[$];

    // responder modes: 0 ready one cycle after cs, 1 ready held one extra
    // cycle, 2 never ready, 3 ready stuck high
    int         mode = 0;
    logic [7:0] mem [0:65535];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        case (mode)
            0, 1: begin
                if (ext_mem_cs && !ext_mem_ready) begin
                    ext_mem_data_in <= mem[ext_mem_addr];
                    if (ext_mem_write) mem[ext_mem_addr] <= ext_mem_data_out;
                end
                ext_mem_ready <= (mode == 1) ? ext_mem_cs : (ext_mem_cs && !ext_mem_ready);
            end
            2: ext_mem_ready <= 1'b0;
            default: ext_mem_ready <= 1'b1;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_rsp: got rsp_valid=1 err=%0b rdata=0x%0h expected none at t=%0t",
                         rsp_error, rsp_rdata, $time);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("rsp_error", {31'd0, rsp_error}, {31'd0, e[8]});
                chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e[7:0]});
            end
        end
    end

    // Returns #1 after the accepting edge (E0).
    task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        int idx;
        int p0;
        int acc1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0000] = 8'h64;
        mem[16'h0002] = 8'h3C;
        ext_mem_ready   = 1'b0;
        ext_mem_data_in = '0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;

        // reset values
        rst = 1'b1;
        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_strobes", {28'd0, ext_mem_cs, ext_mem_read, ext_mem_write, ext_mem_data_oe}, 32'd0);
        chk("rst_rsp", {22'd0, rsp_valid, rsp_error, rsp_rdata}, 32'd0);
        chk("rst_bus", {8'd0, ext_mem_addr, ext_mem_data_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // read 0x0000 with timing
        exp_q.push_back({1'b0, 8'h64});
        issue(1'b0, 16'h0000, 8'h00);
        @(negedge clk);
        chk("rd_e0_strobes", {29'd0, ext_mem_cs, ext_mem_read, ext_mem_write}, 32'b110);
        chk("rd_e0_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("rd_e1_cs", {30'd0, ext_mem_cs, ext_mem_read}, 32'b11);
        @(negedge clk);
        chk("rd_e2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rd_e2_cs", {31'd0, ext_mem_cs}, 32'd0);
        chk("rd_e2_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("rd_e3_ready", {30'd0, req_ready, rsp_valid}, 32'b10);

        // write 0xA5 to 0x0010, rdata keeps 0x64
        exp_q.push_back({1'b0, 8'h64});
        issue(1'b1, 16'h0010, 8'hA5);
        @(negedge clk);
        chk("wr_e0_bus", {14'd0, ext_mem_write, ext_mem_read, ext_mem_data_oe, ext_mem_addr[8:0], ext_mem_data_out[5:0]},
            {14'd0, 1'b1, 1'b0, 1'b1, 9'h010, 6'h25});
        chk("wr_e0_dout", {24'd0, ext_mem_data_out}, 32'hA5);
        @(negedge clk);
        chk("wr_e1_hold", {29'd0, ext_mem_write, ext_mem_data_oe, ext_mem_cs}, 32'b111);
        @(negedge clk);
        chk("wr_e2_oe", {30'd0, ext_mem_data_oe, rsp_valid}, 32'b01);
        @(negedge clk);
        chk("wr_mem", {24'd0, mem[16'h0010]}, 32'hA5);
        chk("wr_e3_oe", {31'd0, ext_mem_data_oe}, 32'd0);

        // timeout with TIMEOUT=8
        mode = 2;
        exp_q.push_back({1'b1, 8'h64});
        issue(1'b0, 16'h0020, 8'h00);
        idx = 0;
        @(negedge clk);
        while (!rsp_valid && idx < 20) begin
            @(negedge clk);
            idx++;
        end
        chk("to_cycles", idx, 32'd8);
        chk("to_strobes", {30'd0, ext_mem_cs, ext_mem_read}, 32'd0);
        repeat (3) @(negedge clk);

        // back-to-back reads, responder holds ready one extra cycle
        mode = 1;
        p0 = pulses;
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'h3C});
        issue(1'b0, 16'h0001, 8'h00);
        acc1 = acc_cyc;
        issue(1'b0, 16'h0002, 8'h00);
        chk("b2b_spacing", acc_cyc - acc1, 32'd4);
        repeat (6) @(negedge clk);
        chk("b2b_pulses", pulses - p0, 32'd2);

        // reset in the middle of an access
        mode = 0;
        p0 = pulses;
        issue(1'b0, 16'h0000, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_strobes", {30'd0, ext_mem_cs, ext_mem_read}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rstmid_no_rsp", pulses - p0, 32'd0);
        exp_q.push_back({1'b0, 8'h64});
        issue(1'b0, 16'h0000, 8'h00);
        repeat (5) @(negedge clk);
        chk("rstmid_reread", pulses - p0, 32'd1);

        // ready stuck high while idle
        mode = 3;
        p0 = pulses;
        repeat (6) @(negedge clk);
        chk("idle_ready_pulses", pulses - p0, 32'd0);
        chk("idle_ready_state", {29'd0, ext_mem_cs, ext_mem_read, req_ready}, 32'b001);
        mode = 0;
        repeat (2) @(negedge clk);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
